comp_bist: RTL and testbench
============================

# comp_bist

Synthesizable built-in self-test engine for the team's `comp_Nbit` magnitude comparators. It is the driving and checking end of the comparator interface. It generates pseudo-random `{a,b}` operand pairs from a seeded LFSR and drives them into a comparator under test. It then samples the comparator's `gt/eq/lt` response, checks it against an internal golden model, and reports pass/fail, an error count and the first failing vector. It sits beside any comparator instance as on-chip test logic, replacing the random-stimulus and monitor loop the comparator bench runs in simulation.

## Interface
Parameters:
- `WIDTH`, default 2: operand width of the comparator under test; legal range 1..8.
- `NUM_VECTORS`, default 15: vectors applied per run; legal range 1..255.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a run; sampled only in IDLE.
- `seed_in` in 16: LFSR seed, captured with `start`.
- `a_out` out WIDTH: operand A to the comparator under test.
- `b_out` out WIDTH: operand B to the comparator under test.
- `dut_gt` in 1: comparator under test's `gt` output.
- `dut_eq` in 1: comparator under test's `eq` output.
- `dut_lt` in 1: comparator under test's `lt` output.
- `busy` out 1: high from the cycle after `start` through the final SAMPLE cycle.
- `done` out 1: one-cycle pulse marking the end of a run.
- `pass` out 1: 1 if the last completed run had zero errors; held until the next `start`.
- `err_count` out 8: mismatching vectors in the current or last run; saturates at 255.
- `vec_count` out 8: vectors checked so far in the current or last run.
- `first_fail_a` out WIDTH: A operand of the first mismatch; 0 if none.
- `first_fail_b` out WIDTH: B operand of the first mismatch; 0 if none.

## Operation
- LFSR is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left. New bit 0 = b15^b13^b12^b10.
- Operand mapping: `a_out` = `lfsr[2*WIDTH-1:WIDTH]`, `b_out` = `lfsr[WIDTH-1:0]`. Both are driven directly from the LFSR register, with no combinational input path.
- Seed handling: a `seed_in` of 0 loads 16'h0001.
- Golden response: exp = {A>B, A==B, A<B}, unsigned.
- Mismatch rule: a vector is an error when `{dut_gt,dut_eq,dut_lt}` != exp. Non-one-hot responses are therefore always errors.
- FSM states:
  - IDLE: on `start`, load LFSR from the seed, clear `err_count`, `vec_count`, `first_fail_*` and `pass`, then go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: operands are stable on `a_out`/`b_out`; a settle cycle. Always go to SAMPLE.
  - SAMPLE: compare the response and increment `vec_count`.
    - On error: increment `err_count` (saturating). If this is the first error, capture `first_fail_a`/`first_fail_b`.
    - Advance the LFSR.
    - If `vec_count` reaches NUM_VECTORS, go to DONE; otherwise go to DRIVE.
  - DONE: assert `done`, set `pass` = (err_count==0), go to IDLE.
- `start` outside IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - State is IDLE and the LFSR holds 16'h0001. With WIDTH=2 this gives `a_out`=0, `b_out`=1.
  - `busy`, `done`, `pass`, `err_count`, `vec_count`, `first_fail_a` and `first_fail_b` are all 0.
- Cycles per run: if `start` is seen at edge 0, vector k (1-based) is in DRIVE at cycle 2k-1 and SAMPLE at cycle 2k. `done` is high at cycle 2*NUM_VECTORS+1.
- Stability: each operand pair is held for exactly 2 cycles. The comparator's outputs are sampled at the end of the second cycle.
- Reset mid-run: `rst` overrides everything at the next edge. All outputs return to their reset values, no `done` is emitted, and the partial results are discarded.
- `rst` and `start` in the same cycle: `rst` wins.
- Back-to-back runs: `start` held high continuously starts a new run in the IDLE cycle that follows DONE.

## Structure
- Package `comp_bist_pkg` holds:
  - the FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3);
  - `LFSR_W`=16;
  - `LFSR_TAPS`=16'hB400;
  - `SAFE_SEED`=16'h0001.
- Sub-module `lfsr16` (ports `clk`, `rst`, `load`, `seed`, `adv`, `q`) holds the LFSR.
- The FSM, golden model and counters live in `comp_bist`.

## Test plan
- Golden comparator, WIDTH=2, seed 16'hACE1, NUM_VECTORS=15 → `done` at cycle 31, `pass`=1, `err_count`=0, `vec_count`=15. The operand sequence matches a reference model of the LFSR.
- Comparator with `gt` and `lt` swapped → `err_count` equals the number of A≠B vectors in the sequence, `pass`=0. `first_fail_a`/`first_fail_b` equal the first unequal pair.
- Comparator with `eq` and `gt` both high when A>B → every A>B vector counts as an error. `err_count` matches the model.
- `seed_in`=0 → operand sequence identical to seed 16'h0001. A `start` pulse at cycle 5 of a run is ignored and `done` still fires at cycle 31.
- `rst` asserted at cycle 10 of a run → next cycle `busy`=0, `err_count`=0, `vec_count`=0, no `done`. A following run completes normally.
- NUM_VECTORS=255 with a stuck-at-`eq`=0 comparator → `err_count` reaches the model's count (≤255), saturation holds at 255, and `done` fires at cycle 511.

Source files
------------

// File: rtl/comp_bist_pkg.sv
// Shared types and constants for the comparator self-test engine.
package comp_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] SAFE_SEED = 16'h0001;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] v
  );
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed falls back to SAFE_SEED.
module lfsr16
  import comp_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? SAFE_SEED : seed;
    end else if (adv) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= SAFE_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/comp_bist.sv
// BIST engine: drives LFSR operand pairs into a magnitude comparator
// and checks its gt/eq/lt response against a golden compare.
module comp_bist
  import comp_bist_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int NUM_VECTORS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             dut_gt,
  input  logic             dut_eq,
  input  logic             dut_lt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       vec_count,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
);

  localparam logic [7:0] LAST = 8'(NUM_VECTORS);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr;
  logic              load, adv, mism;
  logic [2:0]        exp_rsp;
  logic [7:0]        err_q, err_d, vec_q, vec_d, vec_inc;
  logic [WIDTH-1:0]  ffa_q, ffa_d, ffb_q, ffb_d;
  logic              pass_q, pass_d;
  logic              lfsr_unused;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .seed (seed_in),
    .adv  (adv),
    .q    (lfsr)
  );

  assign a_out       = lfsr[2*WIDTH-1:WIDTH];
  assign b_out       = lfsr[WIDTH-1:0];
  assign lfsr_unused = ^lfsr;

  assign exp_rsp = {a_out > b_out, a_out == b_out, a_out < b_out};
  assign mism    = {dut_gt, dut_eq, dut_lt} != exp_rsp;
  assign vec_inc = vec_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SAMPLE;
      S_SAMPLE: state_d = (vec_inc == LAST) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == S_IDLE) && start;
    adv  = (state_q == S_SAMPLE);
    busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
  end

  // Only the first mismatch of a run is latched as the failing vector.
  always_comb begin
    err_d  = err_q;
    vec_d  = vec_q;
    ffa_d  = ffa_q;
    ffb_d  = ffb_q;
    pass_d = pass_q;
    if (load) begin
      err_d  = '0;
      vec_d  = '0;
      ffa_d  = '0;
      ffb_d  = '0;
      pass_d = 1'b0;
    end
    if (adv) begin
      vec_d = vec_inc;
      if (mism) begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
        if (err_q == 8'd0) begin
          ffa_d = a_out;
          ffb_d = b_out;
        end
      end
    end
    if (done) pass_d = (err_q == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      vec_q  <= '0;
      ffa_q  <= '0;
      ffb_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      vec_q  <= vec_d;
      ffa_q  <= ffa_d;
      ffb_q  <= ffb_d;
      pass_q <= pass_d;
    end
  end

  assign pass         = pass_q;
  assign err_count    = err_q;
  assign vec_count    = vec_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_comp_bist.sv
// Bench for comp_bist: table of runs against behavioural comparators,
// plus hand-written reset and back-to-back sequences.
module tb_comp_bist;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   start;
  logic [15:0]  seed;
  logic [2:0]   mode;
  int           sel;

  logic [W-1:0] a0, b0, ffa0, ffb0, a1, b1, ffa1, ffb1;
  logic         gt0, eq0, lt0, gt1, eq1, lt1;
  logic         busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0]   ec0, vc0, ec1, vc1;

  logic [W-1:0] a_s, b_s, ffa_s, ffb_s;
  logic         busy_s, done_s, pass_s;
  logic [7:0]   ec_s, vc_s;

  int n_vec = 0;
  int n_bad = 0;

  // 0 golden, 1 gt/lt swapped, 2 eq also high on A>B,
  // 3 eq stuck at 0, 4 all outputs stuck at 0
  function automatic logic [2:0] resp(
    input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b
  );
    logic g, e, l;
    g = a > b;
    e = a == b;
    l = a < b;
    case (m)
      3'd1:    return {l, e, g};
      3'd2:    return {g, e | g, l};
      3'd3:    return {g, 1'b0, l};
      3'd4:    return 3'b000;
      default: return {g, e, l};
    endcase
  endfunction

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign {gt0, eq0, lt0} = resp(mode, a0, b0);
  assign {gt1, eq1, lt1} = resp(mode, a1, b1);

  comp_bist #(.WIDTH(W), .NUM_VECTORS(15)) u_c15 (
    .clk(clk), .rst(rst), .start(start[0]), .seed_in(seed),
    .a_out(a0), .b_out(b0),
    .dut_gt(gt0), .dut_eq(eq0), .dut_lt(lt0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(ec0), .vec_count(vc0),
    .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  comp_bist #(.WIDTH(W), .NUM_VECTORS(255)) u_c255 (
    .clk(clk), .rst(rst), .start(start[1]), .seed_in(seed),
    .a_out(a1), .b_out(b1),
    .dut_gt(gt1), .dut_eq(eq1), .dut_lt(lt1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .vec_count(vc1),
    .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  always_comb begin
    if (sel == 1) begin
      a_s = a1; b_s = b1; ffa_s = ffa1; ffb_s = ffb1;
      busy_s = busy1; done_s = done1; pass_s = pass1;
      ec_s = ec1; vc_s = vc1;
    end else begin
      a_s = a0; b_s = b0; ffa_s = ffa0; ffb_s = ffb0;
      busy_s = busy0; done_s = done0; pass_s = pass0;
      ec_s = ec0; vc_s = vc0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          s;
    logic [15:0] seed;
    logic [15:0] mseed;
    logic [2:0]  mode;
    int          pulse_at;
    int          rst_at;
    bit          exp_pass;
    bit          sat;
  } vec_t;

  task automatic run(input vec_t v);
    int          nv, cyc, merr;
    logic [15:0] lf;
    logic [W-1:0] ma, mb, mfa, mfb;
    bit          mfail;
    nv = (v.s == 1) ? 255 : 15;
    sel = v.s;
    mode = v.mode;
    @(negedge clk);
    seed = v.seed;
    start[v.s] = 1'b1;
    @(posedge clk);
    lf = v.mseed; merr = 0; mfail = 0;
    ma = '0; mb = '0; mfa = '0; mfb = '0;
    for (cyc = 1; cyc <= 2 * nv + 1; cyc++) begin
      @(negedge clk);
      start[v.s] = (cyc == v.pulse_at);
      if (v.rst_at != 0 && cyc == v.rst_at + 1) begin
        rst = 1'b0;
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_err", ec_s, 0);
        chk("rst_vec", vc_s, 0);
        chk("rst_a", a_s, 0);
        chk("rst_b", b_s, 1);
        break;
      end
      chk("done_timing", done_s, cyc == 2 * nv + 1);
      if (cyc <= 2 * nv) begin
        chk("busy", busy_s, 1);
        if (cyc % 2 == 1) begin
          ma = lf[2*W-1:W];
          mb = lf[W-1:0];
          chk("op_a", a_s, ma);
          chk("op_b", b_s, mb);
        end else begin
          if (resp(v.mode, ma, mb) != resp(3'd0, ma, mb)) begin
            if (merr < 255) merr++;
            if (!mfail) begin mfa = ma; mfb = mb; end
            mfail = 1;
          end
          lf = nxt(lf);
        end
      end else begin
        chk("err_count", ec_s, merr);
        chk("vec_count", vc_s, nv);
        chk("first_a", ffa_s, mfa);
        chk("first_b", ffb_s, mfb);
      end
      if (cyc == v.rst_at) rst = 1'b1;
    end
    if (v.rst_at == 0) begin
      @(negedge clk);
      chk("pass", pass_s, v.exp_pass);
      chk("idle_busy", busy_s, 0);
      chk("idle_done", done_s, 0);
      if (v.sat) chk("sat_255", ec_s, 255);
    end
  endtask

  vec_t tbl[8];
  bit   got;

  initial begin
    tbl[0] = '{0, 16'hACE1, 16'hACE1, 3'd0, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{0, 16'hACE1, 16'hACE1, 3'd1, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{0, 16'h0001, 16'h0001, 3'd2, 0, 0, 1'b0, 1'b0};
    tbl[3] = '{0, 16'h0000, 16'h0001, 3'd0, 5, 0, 1'b1, 1'b0};
    tbl[4] = '{0, 16'hACE1, 16'hACE1, 3'd0, 0, 10, 1'b0, 1'b0};
    tbl[5] = '{0, 16'hBEEF, 16'hBEEF, 3'd0, 0, 0, 1'b1, 1'b0};
    tbl[6] = '{1, 16'hACE1, 16'hACE1, 3'd3, 0, 0, 1'b0, 1'b0};
    tbl[7] = '{1, 16'h1234, 16'h1234, 3'd4, 0, 0, 1'b0, 1'b1};

    rst = 1'b1; start = '0; seed = '0; mode = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a0", a0, 0);
    chk("reset_b0", b0, 1);
    chk("reset_a1", a1, 0);
    chk("reset_b1", b1, 1);
    chk("reset_flags", {busy0, done0, pass0, busy1, done1, pass1}, 0);
    chk("reset_cnt", {ec0, vc0, ec1, vc1}, 0);
    chk("reset_ff", {ffa0, ffb0, ffa1, ffb1}, 0);

    // rst and start together: rst wins
    start[0] = 1'b1; seed = 16'hACE1;
    @(negedge clk);
    chk("rst_start_busy", busy0, 0);
    chk("rst_start_a", a0, 0);
    rst = 1'b0; start[0] = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // start held high: new run begins in the IDLE cycle after DONE
    sel = 0; mode = 3'd0; seed = 16'h0001;
    @(negedge clk);
    start[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = done0;
    end
    chk("b2b_done", got, 1);
    @(negedge clk);
    chk("b2b_idle", busy0, 0);
    chk("b2b_pass", pass0, 1);
    @(negedge clk);
    chk("b2b_restart", busy0, 1);
    start[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
